// File: rtl/instr_packer.sv
// -----------------------------------------------------------------------------
// instr_packer
//
// Packs a stream of variable-length RISC-V instructions back into word-aligned
// 32-bit fetch blocks. This is the inverse of the frontend re-aligner. Each
// block carries a per-halfword valid mask. A 32-bit instruction that starts on
// the upper half of a word is split across two consecutive blocks.
//
// Parameters:
//   VLEN  - address width
//   RVC   - compressed instruction support (0: every instruction is 32-bit)
//
// Ports:
//   clk_i               clock
//   rst_ni              asynchronous reset, active low
//   flush_i             redirect: drop assembly/output state, reload address
//   start_addr_i        new packing address, sampled with flush_i (bit 0 unused)
//   instr_valid_i       input instruction valid
//   instr_i             instruction (upper half don't-care when compressed)
//   instr_ready_o       instruction accepted when valid & ready
//   drain_i             emit a partially filled assembly word
//   block_valid_o       output block valid
//   block_ready_i       consumer accepts block
//   block_addr_o        word-aligned block address
//   block_data_o        packed block data
//   block_half_valid_o  bit0: [15:0] meaningful, bit1: [31:16] meaningful
//   straddle_o          assembly word holds the upper half of a split instr
//
// Optional feature (macro INSTR_PACKER_STATS_EN):
//   blocks_cnt_o        saturating count of block handshakes
//   split_cnt_o         saturating count of split 32-bit instructions
//   Both reset to zero and are cleared by flush_i.
// -----------------------------------------------------------------------------
module instr_packer #(
  parameter int unsigned VLEN = 32,
  parameter bit          RVC  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic [VLEN-1:0] start_addr_i,
  input  logic            instr_valid_i,
  input  logic [31:0]     instr_i,
  output logic            instr_ready_o,
  input  logic            drain_i,
  output logic            block_valid_o,
  input  logic            block_ready_i,
  output logic [VLEN-1:0] block_addr_o,
  output logic [31:0]     block_data_o,
  output logic [1:0]      block_half_valid_o,
  output logic            straddle_o
`ifdef INSTR_PACKER_STATS_EN
  ,
  output logic [31:0]     blocks_cnt_o,
  output logic [31:0]     split_cnt_o
`endif
);

  localparam logic [VLEN-1:0] WordStep = VLEN'(4);

  // Assembly state
  logic [31:0]     asm_data_q, asm_data_d;
  logic [1:0]      asm_mask_q, asm_mask_d;
  logic [VLEN-1:0] asm_addr_q, asm_addr_d;
  logic            pos_q, pos_d;
  logic            straddle_q, straddle_d;

  // Output register
  logic            valid_q, valid_d;
  logic [31:0]     data_q, data_d;
  logic [VLEN-1:0] addr_q, addr_d;
  logic [1:0]      mask_q, mask_d;

  logic slot_free;
  logic accept;
  logic is_c;
  logic drain_fire;
  logic split;

  assign slot_free     = !valid_q || block_ready_i;
  assign instr_ready_o = slot_free && !flush_i;
  assign accept        = instr_valid_i && instr_ready_o;
  assign is_c          = RVC && (instr_i[1:0] != 2'b11);
  // An instruction handshake wins over drain; drain simply retries next cycle.
  assign drain_fire    = drain_i && pos_q && slot_free && !accept && !flush_i;
  assign split         = accept && pos_q && !is_c;

  // Next-state for assembly and output registers. Flush overrides everything.
  always_comb begin
    asm_data_d = asm_data_q;
    asm_mask_d = asm_mask_q;
    asm_addr_d = asm_addr_q;
    pos_d      = pos_q;
    straddle_d = straddle_q;
    valid_d    = valid_q;
    data_d     = data_q;
    addr_d     = addr_q;
    mask_d     = mask_q;

    // A consumed block frees the output register unless refilled below.
    if (block_ready_i) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      if (!pos_q) begin
        if (is_c) begin
          asm_data_d = {16'h0000, instr_i[15:0]};
          asm_mask_d = 2'b01;
          pos_d      = 1'b1;
        end else begin
          valid_d    = 1'b1;
          data_d     = instr_i;
          addr_d     = asm_addr_q;
          mask_d     = 2'b11;
          straddle_d = 1'b0;
          asm_data_d = 32'h0;
          asm_mask_d = 2'b00;
          asm_addr_d = asm_addr_q + WordStep;
        end
      end else begin
        // Upper half completes the current word in both cases.
        valid_d    = 1'b1;
        data_d     = {instr_i[15:0], asm_data_q[15:0]};
        addr_d     = asm_addr_q;
        mask_d     = asm_mask_q | 2'b10;
        asm_addr_d = asm_addr_q + WordStep;
        if (is_c) begin
          asm_data_d = 32'h0;
          asm_mask_d = 2'b00;
          pos_d      = 1'b0;
          straddle_d = 1'b0;
        end else begin
          // High half of the 32-bit instruction starts the next word.
          asm_data_d = {16'h0000, instr_i[31:16]};
          asm_mask_d = 2'b01;
          pos_d      = 1'b1;
          straddle_d = 1'b1;
        end
      end
    end else if (drain_fire) begin
      valid_d    = 1'b1;
      data_d     = asm_data_q;
      addr_d     = asm_addr_q;
      mask_d     = asm_mask_q;
      asm_data_d = 32'h0;
      asm_mask_d = 2'b00;
      asm_addr_d = asm_addr_q + WordStep;
      pos_d      = 1'b0;
      straddle_d = 1'b0;
    end

    if (flush_i) begin
      valid_d    = 1'b0;
      asm_data_d = 32'h0;
      asm_mask_d = 2'b00;
      asm_addr_d = {start_addr_i[VLEN-1:2], 2'b00};
      pos_d      = start_addr_i[1];
      straddle_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_data_q <= 32'h0;
      asm_mask_q <= 2'b00;
      asm_addr_q <= '0;
      pos_q      <= 1'b0;
      straddle_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 32'h0;
      addr_q     <= '0;
      mask_q     <= 2'b00;
    end else begin
      asm_data_q <= asm_data_d;
      asm_mask_q <= asm_mask_d;
      asm_addr_q <= asm_addr_d;
      pos_q      <= pos_d;
      straddle_q <= straddle_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
    end
  end

  assign block_valid_o      = valid_q;
  assign block_data_o       = data_q;
  assign block_addr_o       = addr_q;
  assign block_half_valid_o = mask_q;
  assign straddle_o         = straddle_q;

`ifdef INSTR_PACKER_STATS_EN
  logic [31:0] blk_cnt_q, blk_cnt_d;
  logic [31:0] split_cnt_q, split_cnt_d;

  // Saturating event counters, cleared on redirect.
  always_comb begin
    blk_cnt_d   = blk_cnt_q;
    split_cnt_d = split_cnt_q;
    if (flush_i) begin
      blk_cnt_d   = 32'h0;
      split_cnt_d = 32'h0;
    end else begin
      if (valid_q && block_ready_i && (blk_cnt_q != 32'hFFFF_FFFF)) begin
        blk_cnt_d = blk_cnt_q + 32'd1;
      end
      if (split && (split_cnt_q != 32'hFFFF_FFFF)) begin
        split_cnt_d = split_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      blk_cnt_q   <= 32'h0;
      split_cnt_q <= 32'h0;
    end else begin
      blk_cnt_q   <= blk_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign blocks_cnt_o = blk_cnt_q;
  assign split_cnt_o  = split_cnt_q;
`else
  logic unused_split;
  assign unused_split = split;
`endif

endmodule

// File: tb/tb_instr_packer.sv
// -----------------------------------------------------------------------------
// tb_instr_packer
//
// Directed bench for instr_packer. Stimulus pushes the hand-computed expected
// blocks into a queue; an independent monitor pops and compares each block as
// the consumer accepts it.
// -----------------------------------------------------------------------------
module tb_instr_packer;

  localparam int unsigned VLEN = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  mask;
  } blk_t;

  logic        clk_i;
  logic        rst_ni;
  logic        flush_i;
  logic [31:0] start_addr_i;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        instr_ready_o;
  logic        drain_i;
  logic        block_valid_o;
  logic        block_ready_i;
  logic [31:0] block_addr_o;
  logic [31:0] block_data_o;
  logic [1:0]  block_half_valid_o;
  logic        straddle_o;
`ifdef INSTR_PACKER_STATS_EN
  logic [31:0] blocks_cnt_o;
  logic [31:0] split_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  blk_t expQ[$];

  instr_packer #(.VLEN(VLEN), .RVC(1'b1)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .flush_i            (flush_i),
    .start_addr_i       (start_addr_i),
    .instr_valid_i      (instr_valid_i),
    .instr_i            (instr_i),
    .instr_ready_o      (instr_ready_o),
    .drain_i            (drain_i),
    .block_valid_o      (block_valid_o),
    .block_ready_i      (block_ready_i),
    .block_addr_o       (block_addr_o),
    .block_data_o       (block_data_o),
    .block_half_valid_o (block_half_valid_o),
    .straddle_o         (straddle_o)
`ifdef INSTR_PACKER_STATS_EN
    ,
    .blocks_cnt_o       (blocks_cnt_o),
    .split_cnt_o        (split_cnt_o)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Monitor: a block is consumed at the next rising edge when valid & ready,
  // so it is sampled on the falling edge. Only halves marked valid in the
  // expected mask are compared.
  always @(negedge clk_i) begin
    if (rst_ni && block_valid_o && block_ready_i) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_block got addr=%h data=%h mask=%b required none",
                 block_addr_o, block_data_o, block_half_valid_o);
      end else begin
        blk_t e;
        logic [31:0] m;
        e = expQ.pop_front();
        m = {{16{e.mask[1]}}, {16{e.mask[0]}}};
        if (block_addr_o !== e.addr || block_half_valid_o !== e.mask ||
            (block_data_o & m) !== (e.data & m)) begin
          errors++;
          $display("[TB] FAIL block got addr=%h data=%h mask=%b required addr=%h data=%h mask=%b",
                   block_addr_o, block_data_o, block_half_valid_o, e.addr, e.data, e.mask);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s got %h required %h", name, actual, required);
    end
  endtask

  task automatic expectBlock(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] m);
    blk_t e;
    e.addr = a;
    e.data = d;
    e.mask = m;
    expQ.push_back(e);
  endtask

  // Present one instruction and hold it until the DUT takes it.
  task automatic applyStimulus(input logic [31:0] instr);
    int cyc;
    @(posedge clk_i); #1;
    instr_valid_i = 1'b1;
    instr_i       = instr;
    #1;
    cyc = 0;
    while (!instr_ready_o && cyc < 50) begin
      @(posedge clk_i); #2;
      cyc++;
    end
    if (cyc >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL instr_accept_timeout got ready=0 required ready=1");
    end
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
  endtask

  task automatic doFlush(input logic [31:0] a);
    @(posedge clk_i); #1;
    flush_i      = 1'b1;
    start_addr_i = a;
    @(posedge clk_i); #1;
    flush_i      = 1'b0;
  endtask

  // Wait until every expected block has been seen, bounded.
  task automatic waitEmpty();
    int cyc;
    cyc = 0;
    while (expQ.size() != 0 && cyc < 100) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout got pending=%0d required 0", expQ.size());
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    start_addr_i  = 32'h0;
    instr_valid_i = 1'b0;
    instr_i       = 32'h0;
    drain_i       = 1'b0;
    block_ready_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("reset_valid", {31'h0, block_valid_o}, 32'h0);
    checkOutput("reset_data", block_data_o, 32'h0);
    checkOutput("reset_addr", block_addr_o, 32'h0);
    checkOutput("reset_mask", {30'h0, block_half_valid_o}, 32'h0);
    checkOutput("reset_straddle", {31'h0, straddle_o}, 32'h0);
    rst_ni = 1'b1;
    #1;
    checkOutput("ready_after_reset", {31'h0, instr_ready_o}, 32'h1);
    block_ready_i = 1'b1;

    // Whole word then two compressed
    doFlush(32'h0000_1000);
    expectBlock(32'h0000_1000, 32'h00A0_0093, 2'b11);
    expectBlock(32'h0000_1004, 32'h4585_4501, 2'b11);
    applyStimulus(32'h00A0_0093);
    checkOutput("straddle_t1a", {31'h0, straddle_o}, 32'h0);
    applyStimulus(32'h0000_4501);
    applyStimulus(32'h0000_4585);
    checkOutput("straddle_t1b", {31'h0, straddle_o}, 32'h0);
    waitEmpty();

    // Split 32-bit instruction
    doFlush(32'h0000_2000);
    expectBlock(32'h0000_2000, 32'h5693_4501, 2'b11);
    expectBlock(32'h0000_2004, 32'h0001_1234, 2'b11);
    applyStimulus(32'h0000_4501);
    applyStimulus(32'h1234_5693);
    checkOutput("straddle_set", {31'h0, straddle_o}, 32'h1);
    applyStimulus(32'h0000_0001);
    checkOutput("straddle_clr", {31'h0, straddle_o}, 32'h0);
    waitEmpty();

    // Odd-halfword start address
    doFlush(32'h0000_3002);
    expectBlock(32'h0000_3000, 32'h4505_0000, 2'b10);
    expectBlock(32'h0000_3004, 32'h0000_0013, 2'b11);
    applyStimulus(32'h0000_4505);
    applyStimulus(32'h0000_0013);
    waitEmpty();

    // Backpressure: one block pending, second instruction waiting
    block_ready_i = 1'b0;
    doFlush(32'h0000_5000);
    expectBlock(32'h0000_5000, 32'hAAAA_0013, 2'b11);
    expectBlock(32'h0000_5004, 32'hBBBB_0013, 2'b11);
    applyStimulus(32'hAAAA_0013);
    instr_valid_i = 1'b1;
    instr_i       = 32'hBBBB_0013;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checkOutput("stall_ready", {31'h0, instr_ready_o}, 32'h0);
      checkOutput("stall_valid", {31'h0, block_valid_o}, 32'h1);
      checkOutput("stall_addr", block_addr_o, 32'h0000_5000);
      checkOutput("stall_data", block_data_o, 32'hAAAA_0013);
    end
    @(posedge clk_i); #1;
    block_ready_i = 1'b1;
    #1;
    checkOutput("resume_ready", {31'h0, instr_ready_o}, 32'h1);
    @(posedge clk_i); #1;
    instr_valid_i = 1'b0;
    waitEmpty();

    // Drain a half-filled word, then drain again with nothing held
    doFlush(32'h0000_4000);
    expectBlock(32'h0000_4000, 32'h0000_4501, 2'b01);
    applyStimulus(32'h0000_4501);
    drain_i = 1'b1;
    @(posedge clk_i); #1;
    drain_i = 1'b0;
    waitEmpty();
    drain_i = 1'b1;
    @(posedge clk_i); #1;
    drain_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("second_drain_idle", {31'h0, block_valid_o}, 32'h0);

    // Address wrap
    doFlush(32'hFFFF_FFFC);
    expectBlock(32'hFFFF_FFFC, 32'h0010_0093, 2'b11);
    expectBlock(32'h0000_0000, 32'h0020_0113, 2'b11);
    applyStimulus(32'h0010_0093);
    applyStimulus(32'h0020_0113);
    waitEmpty();

    // Asynchronous reset while a split block is pending
    block_ready_i = 1'b0;
    doFlush(32'h0000_6000);
    applyStimulus(32'h0000_4501);
    applyStimulus(32'h1234_5693);
    checkOutput("pre_reset_valid", {31'h0, block_valid_o}, 32'h1);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("async_valid", {31'h0, block_valid_o}, 32'h0);
    checkOutput("async_data", block_data_o, 32'h0);
    checkOutput("async_addr", block_addr_o, 32'h0);
    checkOutput("async_mask", {30'h0, block_half_valid_o}, 32'h0);
    checkOutput("async_straddle", {31'h0, straddle_o}, 32'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    checkOutput("queue_empty", expQ.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
